rob_id_restore: RTL

Response-side counterpart of the request ID allocator in the reorder-buffer path. Records every issued unique ID `{row, col}` with its original AXI ID. On each returning response beat it restores the original ID and passes the beat downstream through a one-stage registered handshake. On the last beat it retires the `{row, col}` slot, and it pulses a row-release when a row has no outstanding transactions left.

---
 rtl/rob_id_restore.sv | 134 +++++++++++++
 1 files changed

// File: rtl/rob_id_restore.sv
// rob_id_restore: restores original AXI IDs on returning response beats and
// retires unique-ID slots, pulsing a row release once a row fully drains.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   alloc_valid/uid/orig_id       issued unique ID and its original ID
//   rsp_valid/ready/uid/last      incoming response beat (valid/ready)
//   out_valid/ready/orig_id/uid/last  registered restored beat
//   rel_valid/rel_row             one-cycle row-drained pulse
//   err_alloc/err_rsp             one-cycle rejection/drop pulses
module rob_id_restore #(
    parameter int ID_WIDTH        = 4,
    parameter int MAX_OUTSTANDING = 16,
    localparam int IDX_W          = $clog2(MAX_OUTSTANDING),
    localparam int UID_W          = 2 * IDX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                alloc_valid,
    input  logic [UID_W-1:0]    alloc_uid,
    input  logic [ID_WIDTH-1:0] alloc_orig_id,
    input  logic                rsp_valid,
    output logic                rsp_ready,
    input  logic [UID_W-1:0]    rsp_uid,
    input  logic                rsp_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ID_WIDTH-1:0] out_orig_id,
    output logic [UID_W-1:0]    out_uid,
    output logic                out_last,
    output logic                rel_valid,
    output logic [IDX_W-1:0]    rel_row,
    output logic                err_alloc,
    output logic                err_rsp
);

    localparam int CNT_W = IDX_W + 1;

    logic [MAX_OUTSTANDING-1:0] pending [MAX_OUTSTANDING];
    logic [ID_WIDTH-1:0]        row_id  [MAX_OUTSTANDING];
    logic [CNT_W-1:0]           row_cnt [MAX_OUTSTANDING];

    logic [IDX_W-1:0] a_row;
    logic [IDX_W-1:0] a_col;
    logic [IDX_W-1:0] r_row;
    logic [IDX_W-1:0] r_col;

    logic             rsp_acc;
    logic             rsp_hit;
    logic             retire;
    logic             same_row;
    logic             a_pend;
    logic [CNT_W-1:0] a_cnt;
    logic             alloc_ok;
    logic             release_row;

    assign a_row = alloc_uid[UID_W-1:IDX_W];
    assign a_col = alloc_uid[IDX_W-1:0];
    assign r_row = rsp_uid[UID_W-1:IDX_W];
    assign r_col = rsp_uid[IDX_W-1:0];

    assign rsp_ready = !out_valid || out_ready;
    assign rsp_acc   = rsp_valid && rsp_ready;
    assign rsp_hit   = rsp_acc && pending[r_row][r_col];
    assign retire    = rsp_hit && rsp_last;
    assign same_row  = (a_row == r_row);

    // The allocation sees the table as it stands after this cycle's
    // retire, so a slot or row freed now can be reused in the same cycle.
    assign a_pend = pending[a_row][a_col]
                    && !(retire && same_row && (a_col == r_col));
    assign a_cnt  = (retire && same_row) ? row_cnt[a_row] - CNT_W'(1)
                                         : row_cnt[a_row];

    assign alloc_ok = alloc_valid && !a_pend
                      && ((a_cnt == '0) || (alloc_orig_id == row_id[a_row]));

    // A row refilled in the same cycle it drains never reports a release.
    assign release_row = retire && (row_cnt[r_row] == CNT_W'(1))
                         && !(alloc_ok && same_row);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                pending[i] <= '0;
                row_id[i]  <= '0;
                row_cnt[i] <= '0;
            end
        end else begin
            // Set after clear so a same-slot alloc leaves the bit high.
            if (retire)
                pending[r_row][r_col] <= 1'b0;
            if (alloc_ok)
                pending[a_row][a_col] <= 1'b1;

            if (retire && !(alloc_ok && same_row))
                row_cnt[r_row] <= row_cnt[r_row] - CNT_W'(1);
            if (alloc_ok && !(retire && same_row))
                row_cnt[a_row] <= row_cnt[a_row] + CNT_W'(1);

            if (alloc_ok && (a_cnt == '0))
                row_id[a_row] <= alloc_orig_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid   <= 1'b0;
            out_orig_id <= '0;
            out_uid     <= '0;
            out_last    <= 1'b0;
            rel_valid   <= 1'b0;
            rel_row     <= '0;
            err_alloc   <= 1'b0;
            err_rsp     <= 1'b0;
        end else begin
            err_rsp   <= rsp_acc && !rsp_hit;
            err_alloc <= alloc_valid && !alloc_ok;
            rel_valid <= release_row;
            if (release_row)
                rel_row <= r_row;

            if (rsp_hit) begin
                out_valid   <= 1'b1;
                out_orig_id <= row_id[r_row];
                out_uid     <= rsp_uid;
                out_last    <= rsp_last;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
